// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read channel between fetch_unit (master) and memory (slave)
//   imem_req    master -> slave  read request, held until imem_ack
//   imem_addr   master -> slave  word-aligned read address
//   imem_ack    slave -> master  one-cycle pulse, imem_rdata valid in that cycle
//   imem_rdata  slave -> master  fetched instruction word
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with a one-entry skid buffer and branch redirect
//   clk, rst            clock; asynchronous active-low reset
//   freeze              decode-side hazard, holds the delivered instruction
//   branch_taken/addr   redirect request and its word-aligned target
//   imem                instruction-memory read channel (master side)
//   PC, instruction     delivered word and its fetch address + 4 (instruction 0 when invalid)
//   valid               PC/instruction hold a real fetched instruction
module fetch_unit (
   input  logic         clk,
   input  logic         rst,
   input  logic         freeze,
   input  logic         branch_taken,
   input  logic [31:0]  branch_addr,
   fetch_unit_if.master imem,
   output logic [31:0]  PC,
   output logic [31:0]  instruction,
   output logic         valid
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] FETCH   = 2'd1;
   localparam logic [1:0] DISCARD = 2'd2;
   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d, req_addr_q, req_addr_d;
   logic        valid_q, valid_d, skid_v_q, skid_v_d;
   logic [31:0] instr_q, instr_d, out_pc_q, out_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d, skid_pc_q, skid_pc_d;
   logic        take, drain, direct;
   logic [31:0] seq_addr;
   // only FETCH accepts a word; an ack in DISCARD or IDLE is dropped
   assign take     = state_q == FETCH && imem.imem_ack;
   assign drain    = !freeze && skid_v_q;
   assign direct   = take && (!freeze || !valid_q) && !skid_v_q;
   assign seq_addr = req_addr_q + 32'd4;
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_addr_d   = req_addr_q;
      valid_d      = valid_q;
      instr_d      = instr_q;
      out_pc_d     = out_pc_q;
      skid_v_d     = skid_v_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      if (direct) begin
         valid_d  = 1'b1;
         instr_d  = imem.imem_rdata;
         out_pc_d = seq_addr;
      end else if (drain) begin
         valid_d  = 1'b1;
         instr_d  = skid_instr_q;
         out_pc_d = skid_pc_q;
         skid_v_d = 1'b0;
      end else if (!freeze) begin
         valid_d = 1'b0;
         instr_d = '0;
      end
      // a word that cannot go straight to the output parks in the skid (possibly refilling it as it drains)
      if (take && !direct) begin
         skid_v_d     = 1'b1;
         skid_instr_d = imem.imem_rdata;
         skid_pc_d    = seq_addr;
      end
      case (state_q)
         IDLE: if (!skid_v_q) begin
            state_d    = FETCH;
            req_addr_d = pc_q;
         end
         FETCH: if (take) begin
            pc_d       = pc_q + 32'd4;
            req_addr_d = pc_q + 32'd4;
            state_d    = skid_v_d ? IDLE : FETCH;
         end
         DISCARD: if (imem.imem_ack) begin
            state_d    = FETCH;
            req_addr_d = pc_q;
         end
         default: state_d = IDLE;
      endcase
      // redirect wins over everything; an unacked request must still complete, so it is waited out in DISCARD
      if (branch_taken) begin
         valid_d    = 1'b0;
         instr_d    = '0;
         skid_v_d   = 1'b0;
         pc_d       = branch_addr;
         state_d    = (state_q != IDLE && !imem.imem_ack) ? DISCARD : FETCH;
         req_addr_d = (state_d == FETCH) ? branch_addr : req_addr_q;
      end
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q      <= IDLE;
         pc_q         <= '0;
         req_addr_q   <= '0;
         valid_q      <= 1'b0;
         instr_q      <= '0;
         out_pc_q     <= '0;
         skid_v_q     <= 1'b0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_addr_q   <= req_addr_d;
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         out_pc_q     <= out_pc_d;
         skid_v_q     <= skid_v_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   assign imem.imem_req  = state_q != IDLE;
   assign imem.imem_addr = req_addr_q;
   assign PC             = out_pc_q;
   assign instruction    = instr_q;
   assign valid          = valid_q;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-003 SHALL have port freeze  input  1  decode-side hazard; 1 = hold the delivered instruction.
REQ-004 SHALL have port branch_taken  input  1  redirect request from execute.
REQ-005 SHALL have port branch_addr  input  32  redirect target, word aligned.
REQ-006 SHALL have port imem_req  output  1  instruction memory read request.
REQ-007 SHALL have port imem_addr  output  32  read address, stable while imem_req=1 and no ack.
REQ-008 SHALL have port imem_ack  input  1  one-cycle pulse; imem_rdata valid in that cycle.
REQ-009 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-010 SHALL have port PC  output  32  fetch address + 4 of the delivered instruction.
REQ-011 SHALL have port instruction  output  32  delivered instruction; 0 when invalid.
REQ-012 SHALL have port valid  output  1  1 = PC/instruction hold a real fetched instruction.

Function
REQ-013 SHALL hold registers: pc (next fetch address), req_addr, output register (valid/instruction/PC), one-entry skid buffer, FSM state.
REQ-014 SHALL implement states IDLE (imem_req=0), FETCH (imem_req=1), DISCARD (imem_req=1, data dropped); imem_addr=req_addr always.
REQ-015 SHALL allow at most one outstanding memory request.
REQ-016 IDLE -> FETCH when skid empty, with req_addr<=pc; otherwise remain IDLE.
REQ-017 FETCH with imem_ack and no branch: pc<=pc+4 (mod 2^32, wrap to 0); word routed per REQ-019; next state FETCH with req_addr<=pc+4 if skid empty after this cycle, else IDLE.
REQ-018 FETCH without imem_ack: req_addr and imem_req held unchanged.
REQ-019 Routing on accepted ack: if output consumable (freeze=0 or valid=0) and skid empty -> output register {1, rdata, req_addr+4}; else -> skid buffer.
REQ-020 When freeze=0 and skid full: output <= skid, skid cleared the same edge; a same-cycle ack word then goes to skid.
REQ-021 When freeze=0, skid empty and no ack: output becomes bubble (valid=0, instruction=0, PC unchanged).
REQ-022 When freeze=1 and valid=1: output register unchanged.
REQ-023 branch_taken has priority over freeze and ack: output valid<=0, instruction<=0, skid cleared, pc<=branch_addr.
REQ-024 Branch in FETCH without ack -> DISCARD (request kept, address unchanged); branch in FETCH with ack -> data dropped, FETCH with req_addr<=branch_addr; branch in IDLE -> FETCH with req_addr<=branch_addr.
REQ-025 DISCARD on imem_ack: data dropped, -> FETCH with req_addr<=pc; branch during DISCARD updates pc only, state unchanged (if same-cycle ack, req_addr<=branch_addr).
REQ-026 No instruction SHALL ever be delivered twice, skipped, or delivered out of fetch order between redirects.

Reset
REQ-027 rst=0 SHALL asynchronously set state=IDLE, pc=0, req_addr=0, skid empty, valid=0, instruction=0, PC=0, imem_req=0.
REQ-028 Reset during an outstanding request SHALL abandon it; a late imem_ack after reset release in IDLE SHALL be ignored.
REQ-029 First request (imem_addr=0) SHALL be raised the cycle after rst deasserts.

Verification
REQ-030 Zero-wait memory (ack the cycle after req), freeze=0: words A0,A1,A2 from 0,4,8 -> valid stream with PC=4,8,12, one new instruction per two cycles, no gaps beyond FSM turnaround.
REQ-031 freeze=1 for 4 cycles while delivering addr 8: output holds PC=12; next word captured in skid, state IDLE, imem_req=0; after release PC=16 then PC=20 with no loss.
REQ-032 branch_taken with branch_addr=0x100 while request to 0x10 outstanding (ack 3 cycles later): valid drops next edge, 0x10 data discarded, next imem_addr=0x100, delivered PC=0x104.
REQ-033 branch_taken while freeze=1 and skid full: output and skid flushed, valid=0, next delivered PC=branch_addr+4.
REQ-034 pc=0xFFFFFFFC fetched: delivered PC=0x00000000, next imem_addr=0x00000000.
REQ-035 rst asserted mid-request: all outputs 0 immediately; stale ack after release ignored; first imem_addr=0.
